// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, instruction
// field positions, FSM state encoding and condition-flag bit indices.
package cpu_pkg;

    // Opcodes, instruction bits [31:27]
    localparam logic [4:0] OP_MOVSGPR  = 5'b00000;
    localparam logic [4:0] OP_MOV      = 5'b00001;
    localparam logic [4:0] OP_ADD      = 5'b00010;
    localparam logic [4:0] OP_SUB      = 5'b00011;
    localparam logic [4:0] OP_MUL      = 5'b00100;
    localparam logic [4:0] OP_AND      = 5'b00101;
    localparam logic [4:0] OP_OR       = 5'b00110;
    localparam logic [4:0] OP_XOR      = 5'b00111;
    localparam logic [4:0] OP_NOT      = 5'b01000;
    localparam logic [4:0] OP_STOREREG = 5'b01101;
    localparam logic [4:0] OP_STOREDIN = 5'b01110;
    localparam logic [4:0] OP_SENDDOUT = 5'b01111;
    localparam logic [4:0] OP_SENDREG  = 5'b10001;
    localparam logic [4:0] OP_JUMP     = 5'b10010;
    localparam logic [4:0] OP_JCARRY   = 5'b10011;
    localparam logic [4:0] OP_JZERO    = 5'b10100;
    localparam logic [4:0] OP_JNZERO   = 5'b10101;
    localparam logic [4:0] OP_HALT     = 5'b11011;

    // Instruction field positions
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 27;
    localparam int RD_HI   = 26;
    localparam int RD_LO   = 22;
    localparam int RS1_HI  = 21;
    localparam int RS1_LO  = 17;
    localparam int IMM_BIT = 16;
    localparam int RS2_HI  = 15;
    localparam int RS2_LO  = 11;
    localparam int ISRC_HI = 15;
    localparam int ISRC_LO = 0;

    // Condition flag bit indices
    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_HALT
    } state_e;

    // Ops whose ALU result updates the condition flags
    function automatic logic sets_flags(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND,
                          OP_OR, OP_XOR, OP_NOT};
    endfunction

    // Ops whose GPR destination takes the registered ALU result
    function automatic logic alu_writes_gpr(input logic [4:0] op);
        return op inside {OP_MOV, OP_ADD, OP_SUB, OP_MUL,
                          OP_AND, OP_OR, OP_XOR, OP_NOT};
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multi-cycle core.
// Ports: a_i/b_i operands, op_i opcode; res_o low result, hi_o
// high half of the product (mul only), flags_o {V,C,S,Z}.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [4:0]    op_i,
    output logic [DW-1:0] res_o,
    output logic [DW-1:0] hi_o,
    output logic [3:0]    flags_o
);

    logic [DW:0]     sum;
    logic [DW:0]     diff;
    logic [2*DW-1:0] prod;
    logic            carry;
    logic            ovf;

    always_comb begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        // diff[DW] is the unsigned borrow, i.e. a_i < b_i
        diff  = {1'b0, a_i} - {1'b0, b_i};
        prod  = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
        res_o = '0;
        hi_o  = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op_i)
            OP_MOV: res_o = b_i;
            OP_ADD: begin
                res_o = sum[DW-1:0];
                carry = sum[DW];
                ovf   = (a_i[DW-1] == b_i[DW-1]) &&
                        (sum[DW-1] != a_i[DW-1]);
            end
            OP_SUB: begin
                res_o = diff[DW-1:0];
                carry = diff[DW];
                ovf   = (a_i[DW-1] != b_i[DW-1]) &&
                        (diff[DW-1] != a_i[DW-1]);
            end
            OP_MUL: begin
                res_o = prod[DW-1:0];
                hi_o  = prod[2*DW-1:DW];
                carry = |prod[2*DW-1:DW];
            end
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_NOT: res_o = ~a_i;
            default: ;
        endcase
        flags_o         = '0;
        flags_o[FLAG_Z] = (res_o == '0);
        flags_o[FLAG_S] = res_o[DW-1];
        flags_o[FLAG_C] = carry;
        flags_o[FLAG_V] = ovf;
    end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle processor core: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// FSM with writable imem, dmem, GPR file, SGPR and condition flags.
// Ports: clk, sys_rst (async, high); din/din_valid/din_ready input
// handshake; dout/dout_valid output pulse; imem_we/imem_addr/
// imem_wdata program load; halted, pc status.
module multicycle_core
    import cpu_pkg::*;
#(
    parameter int DW         = 16,
    parameter int NREG       = 32,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic [DW-1:0]                 din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [DW-1:0]                 dout,
    output logic                          dout_valid,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    output logic                          halted,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam int RW  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0] NREG_L = 6'(NREG);

    logic [31:0]   imem_q [IMEM_DEPTH];
    logic [DW-1:0] dmem_q [DMEM_DEPTH];
    logic [DW-1:0] gpr_q  [NREG];

    state_e        state_q;
    logic [IAW-1:0] pc_q;
    logic [31:0]   ir_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] res_q;
    logic [DW-1:0] hi_q;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] sgpr_q;
    logic [DW-1:0] dout_q;
    logic [3:0]    flags_q;
    logic          din_ready_q;
    logic          dout_valid_q;
    logic          halted_q;

    // Decoded instruction fields
    logic [4:0]    op;
    logic [4:0]    rdst;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          imm_mode;
    logic [15:0]   isrc;
    logic [DAW-1:0] daddr;
    logic [IAW-1:0] target;

    assign op       = ir_q[OP_HI:OP_LO];
    assign rdst     = ir_q[RD_HI:RD_LO];
    assign rs1      = ir_q[RS1_HI:RS1_LO];
    assign rs2      = ir_q[RS2_HI:RS2_LO];
    assign imm_mode = ir_q[IMM_BIT];
    assign isrc     = ir_q[ISRC_HI:ISRC_LO];
    assign daddr    = isrc[DAW-1:0];
    assign target   = isrc[IAW-1:0];

    // Register reads; indices beyond the file read as zero
    logic [DW-1:0] rs1_val;
    logic [DW-1:0] rs2_val;
    logic          rd_ok;

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if ({1'b0, rs1} < NREG_L) rs1_val = gpr_q[rs1[RW-1:0]];
        if ({1'b0, rs2} < NREG_L) rs2_val = gpr_q[rs2[RW-1:0]];
        rd_ok = ({1'b0, rdst} < NREG_L);
    end

    logic [DW-1:0] alu_res;
    logic [DW-1:0] alu_hi;
    logic [3:0]    alu_flags;

    cpu_alu #(
        .DW(DW)
    ) u_alu (
        .a_i    (a_q),
        .b_i    (b_q),
        .op_i   (op),
        .res_o  (alu_res),
        .hi_o   (alu_hi),
        .flags_o(alu_flags)
    );

    // Writeback selection and branch resolution
    logic          wb_en;
    logic [DW-1:0] wb_val;
    logic          jump_taken;
    logic [IAW-1:0] pc_next;

    always_comb begin
        wb_en      = alu_writes_gpr(op);
        wb_val     = res_q;
        jump_taken = 1'b0;
        case (op)
            OP_MOVSGPR: begin
                wb_en  = 1'b1;
                wb_val = sgpr_q;
            end
            OP_SENDREG: begin
                wb_en  = 1'b1;
                wb_val = mem_q;
            end
            OP_JUMP:   jump_taken = 1'b1;
            OP_JCARRY: jump_taken = flags_q[FLAG_C];
            OP_JZERO:  jump_taken = flags_q[FLAG_Z];
            OP_JNZERO: jump_taken = !flags_q[FLAG_Z];
            default: ;
        endcase
        pc_next = jump_taken ? target : pc_q + 1'b1;
    end

    // Data memory port; storedin writes only on the accepting cycle
    logic          dmem_we;
    logic [DW-1:0] dmem_wdata_d;

    always_comb begin
        dmem_we = (state_q == S_MEMORY) &&
                  ((op == OP_STOREREG) ||
                   (op == OP_STOREDIN && din_valid && din_ready_q));
        dmem_wdata_d = (op == OP_STOREDIN) ? din : a_q;
    end

    always_ff @(posedge clk) begin
        if (dmem_we) dmem_q[daddr] <= dmem_wdata_d;
    end

    // Host load port is independent of core state and reset
    always_ff @(posedge clk) begin
        if (imem_we) imem_q[imem_addr] <= imem_wdata;
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            hi_q         <= '0;
            mem_q        <= '0;
            sgpr_q       <= '0;
            dout_q       <= '0;
            flags_q      <= '0;
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
        end else begin
            dout_valid_q <= 1'b0;
            unique case (state_q)
                S_FETCH: begin
                    ir_q    <= imem_q[pc_q];
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    a_q     <= rs1_val;
                    b_q     <= imm_mode ? isrc[DW-1:0] : rs2_val;
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    res_q <= alu_res;
                    hi_q  <= alu_hi;
                    if (sets_flags(op)) flags_q <= alu_flags;
                    din_ready_q <= (op == OP_STOREDIN);
                    state_q     <= S_MEMORY;
                end
                S_MEMORY: begin
                    if (op == OP_STOREDIN) begin
                        // Stall here until the producer offers data
                        if (din_valid) begin
                            din_ready_q <= 1'b0;
                            state_q     <= S_WRITEBACK;
                        end
                    end else begin
                        if (op == OP_SENDDOUT) begin
                            dout_q       <= dmem_q[daddr];
                            dout_valid_q <= 1'b1;
                        end
                        if (op == OP_SENDREG) mem_q <= dmem_q[daddr];
                        state_q <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    if (wb_en && rd_ok) gpr_q[rdst[RW-1:0]] <= wb_val;
                    if (op == OP_MUL) sgpr_q <= hi_q;
                    if (op == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        pc_q    <= pc_next;
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign din_ready  = din_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign halted     = halted_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: programs are loaded through
// the imem port, dout values are scoreboarded, pc/flags via jumps.
module tb_multicycle_core;

    localparam logic [4:0] MOVSGPR = 5'b00000;
    localparam logic [4:0] MOV     = 5'b00001;
    localparam logic [4:0] ADD     = 5'b00010;
    localparam logic [4:0] SUB     = 5'b00011;
    localparam logic [4:0] MUL     = 5'b00100;
    localparam logic [4:0] STREG   = 5'b01101;
    localparam logic [4:0] STDIN   = 5'b01110;
    localparam logic [4:0] SDOUT   = 5'b01111;
    localparam logic [4:0] JUMP    = 5'b10010;
    localparam logic [4:0] JCARRY  = 5'b10011;
    localparam logic [4:0] JZERO   = 5'b10100;
    localparam logic [4:0] JNZERO  = 5'b10101;
    localparam logic [4:0] HALT    = 5'b11011;

    typedef logic [31:0] prog_t [16];

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] dout;
    logic        dout_valid;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_addr = '0;
    logic [31:0] imem_wdata = '0;
    logic        halted;
    logic [3:0]  pc;

    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;
    bit          dv_prev = 1'b0;

    multicycle_core #(
        .DW(16), .NREG(32), .IMEM_DEPTH(16), .DMEM_DEPTH(16)
    ) dut (
        .clk(clk), .sys_rst(sys_rst),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .halted(halted), .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ei(input logic [4:0] op,
        input logic [4:0] rd, input logic [4:0] rs1,
        input logic [15:0] imm);
        return {op, rd, rs1, 1'b1, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] op,
        input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 11'd0};
    endfunction

    // Scoreboard: each dout pulse pops one expected value
    always @(negedge clk) begin
        if (!sys_rst && dout_valid) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL dout_extra: got %h, none expected", dout);
            end else begin
                exp_v = exp_q.pop_front();
                if (dout !== exp_v) begin
                    mismatched++;
                    $display("FAIL dout_value: got %h, want %h",
                             dout, exp_v);
                end
            end
            compared++;
            if (dv_prev !== 1'b0) begin
                mismatched++;
                $display("FAIL dout_pulse: valid high 2 cycles");
            end
        end
        dv_prev = dout_valid && !sys_rst;
    end

    function automatic prog_t halt_fill();
        prog_t p;
        for (int i = 0; i < 16; i++) p[i] = ei(HALT, 0, 0, 0);
        return p;
    endfunction

    // Load under reset, then release on a falling edge
    task automatic load_and_run(input prog_t p);
        sys_rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            imem_we    = 1'b1;
            imem_addr  = 4'(i);
            imem_wdata = p[i];
        end
        @(negedge clk);
        imem_we = 1'b0;
        sys_rst = 1'b0;
    endtask

    task automatic run_to_halt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if ({halted, pc, dout, dout_valid, din_ready} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got h%b pc%h d%h v%b r%b, want 0",
                     halted, pc, dout, dout_valid, din_ready);
        end
    endtask

    task automatic test_arith();
        prog_t p;
        bit ok;
        p = halt_fill();
        p[0] = ei(MOV, 1, 0, 16'd5);
        p[1] = ei(MOV, 2, 0, 16'd3);
        p[2] = er(ADD, 3, 1, 2);
        p[3] = ei(STREG, 0, 3, 16'd4);
        p[4] = ei(SDOUT, 0, 0, 16'd4);
        p[5] = ei(JZERO, 0, 0, 16'd9);
        p[6] = ei(JCARRY, 0, 0, 16'd9);
        exp_q.push_back(16'd8);
        load_and_run(p);
        repeat (4) @(negedge clk);
        compared++;
        if (pc !== 4'd0) begin
            mismatched++;
            $display("FAIL arith_pc_c4: got %0d, want 0", pc);
        end
        @(negedge clk);
        compared++;
        if (pc !== 4'd1) begin
            mismatched++;
            $display("FAIL arith_pc_c5: got %0d, want 1", pc);
        end
        repeat (5) @(negedge clk);
        compared++;
        if (pc !== 4'd2) begin
            mismatched++;
            $display("FAIL arith_pc_c10: got %0d, want 2", pc);
        end
        run_to_halt(200, ok);
        compared++;
        if (!ok || pc !== 4'd7) begin
            mismatched++;
            $display("FAIL arith_halt: halted %b pc %0d, want 1 pc 7",
                     ok, pc);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL arith_drain: %0d left, want 0", exp_q.size());
        end
    endtask

    task automatic test_carry_mul();
        prog_t p;
        bit ok;
        p = halt_fill();
        p[0]  = ei(MOV, 1, 0, 16'hFFFF);
        p[1]  = ei(ADD, 2, 1, 16'd1);
        p[2]  = ei(JCARRY, 0, 0, 16'd4);
        p[4]  = ei(JZERO, 0, 0, 16'd6);
        p[6]  = ei(STREG, 0, 2, 16'd1);
        p[7]  = ei(SDOUT, 0, 0, 16'd1);
        p[8]  = er(MUL, 3, 1, 1);
        p[9]  = ei(MOVSGPR, 4, 0, 16'd0);
        p[10] = ei(STREG, 0, 3, 16'd2);
        p[11] = ei(SDOUT, 0, 0, 16'd2);
        p[12] = ei(STREG, 0, 4, 16'd3);
        p[13] = ei(SDOUT, 0, 0, 16'd3);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'hFFFE);
        load_and_run(p);
        run_to_halt(200, ok);
        compared++;
        if (!ok || pc !== 4'd14) begin
            mismatched++;
            $display("FAIL carry_halt: halted %b pc %0d, want 1 pc 14",
                     ok, pc);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL carry_drain: %0d left, want 0", exp_q.size());
        end
    endtask

    task automatic test_storedin();
        prog_t p;
        bit ok;
        p = halt_fill();
        p[0] = ei(STDIN, 0, 0, 16'd4);
        p[1] = ei(SDOUT, 0, 0, 16'd4);
        p[2] = ei(MOV, 3, 0, 16'h00A5);
        p[3] = ei(STREG, 0, 3, 16'd20);
        p[4] = ei(SDOUT, 0, 0, 16'd4);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h00A5);
        din_valid = 1'b0;
        load_and_run(p);
        repeat (2) @(negedge clk);
        compared++;
        if (din_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL din_ready_early: got %b, want 0", din_ready);
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            compared++;
            if (din_ready !== 1'b1 || pc !== 4'd0) begin
                mismatched++;
                $display("FAIL din_stall: ready %b pc %0d, want 1 pc 0",
                         din_ready, pc);
            end
            @(negedge clk);
        end
        din       = 16'h1234;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din       = 16'hDEAD;
        compared++;
        if (din_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL din_accept: ready %b, want 0", din_ready);
        end
        run_to_halt(200, ok);
        compared++;
        if (!ok || pc !== 4'd5) begin
            mismatched++;
            $display("FAIL din_halt: halted %b pc %0d, want 1 pc 5",
                     ok, pc);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (dout !== 16'h00A5 || dout_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL dout_hold: got %h v%b, want 00a5 v0",
                     dout, dout_valid);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL din_drain: %0d left, want 0", exp_q.size());
        end
    endtask

    task automatic test_jumps_wrap();
        prog_t p;
        bit ok;
        p = halt_fill();
        p[0]  = ei(JZERO, 0, 0, 16'd14);
        p[1]  = ei(MOV, 1, 0, 16'd9);
        p[2]  = er(SUB, 1, 1, 1);
        p[3]  = ei(JZERO, 0, 0, 16'd7);
        p[7]  = ei(JNZERO, 0, 0, 16'd2);
        p[8]  = ei(JUMP, 0, 0, 16'd15);
        p[15] = {5'b01001, 27'd0};
        load_and_run(p);
        repeat (20) @(negedge clk);
        compared++;
        if (pc !== 4'd7) begin
            mismatched++;
            $display("FAIL jzero_taken: pc %0d, want 7", pc);
        end
        repeat (5) @(negedge clk);
        compared++;
        if (pc !== 4'd8) begin
            mismatched++;
            $display("FAIL jnzero_not_taken: pc %0d, want 8", pc);
        end
        repeat (5) @(negedge clk);
        compared++;
        if (pc !== 4'd15) begin
            mismatched++;
            $display("FAIL jump: pc %0d, want 15", pc);
        end
        repeat (5) @(negedge clk);
        compared++;
        if (pc !== 4'd0) begin
            mismatched++;
            $display("FAIL pc_wrap: pc %0d, want 0", pc);
        end
        repeat (5) @(negedge clk);
        compared++;
        if (pc !== 4'd14) begin
            mismatched++;
            $display("FAIL jzero_second: pc %0d, want 14", pc);
        end
        run_to_halt(50, ok);
        compared++;
        if (!ok || pc !== 4'd14) begin
            mismatched++;
            $display("FAIL jump_halt: halted %b pc %0d, want 1 pc 14",
                     ok, pc);
        end
    endtask

    task automatic test_halt_reset();
        prog_t p;
        bit ok;
        p = halt_fill();
        p[0] = ei(MOV, 1, 0, 16'd7);
        p[1] = ei(STREG, 0, 1, 16'd0);
        p[2] = ei(SDOUT, 0, 0, 16'd0);
        exp_q.push_back(16'd7);
        load_and_run(p);
        run_to_halt(200, ok);
        compared++;
        if (!ok || pc !== 4'd3) begin
            mismatched++;
            $display("FAIL halt_reach: halted %b pc %0d, want 1 pc 3",
                     ok, pc);
        end
        repeat (20) @(negedge clk);
        compared++;
        if (halted !== 1'b1 || pc !== 4'd3 || dout !== 16'd7) begin
            mismatched++;
            $display("FAIL halt_frozen: h%b pc %0d d%h, want 1 3 0007",
                     halted, pc, dout);
        end
        #2 sys_rst = 1'b1;
        #1;
        compared++;
        if ({halted, pc, dout, dout_valid, din_ready} !== '0) begin
            mismatched++;
            $display("FAIL reset_halted: h%b pc%h d%h v%b r%b, want 0",
                     halted, pc, dout, dout_valid, din_ready);
        end
        p = halt_fill();
        p[0] = ei(STDIN, 0, 0, 16'd0);
        load_and_run(p);
        repeat (6) @(negedge clk);
        compared++;
        if (din_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_before_rst: ready %b, want 1", din_ready);
        end
        #2 sys_rst = 1'b1;
        #1;
        compared++;
        if (din_ready !== 1'b0 || pc !== 4'd0 || halted !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_stall: r%b pc%0d h%b, want 0 0 0",
                     din_ready, pc, halted);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_carry_mul();
        test_storedin();
        test_jumps_wrap();
        test_halt_reset();
        sys_rst = 1'b1;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
